// File: rtl/qspi_xip_reader_pkg.sv
// Shared types and constants for the QSPI XIP read engine.
package qspi_flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_MODE,
    ST_DUMMY,
    ST_DATA,
    ST_CSH
  } state_t;

  localparam int CMD_SCKS  = 8;
  localparam int ADDR_SCKS = 6;
  localparam int MODE_SCKS = 2;

  localparam logic [7:0] DEFAULT_CMD = 8'hEB;

  // Countdown counters run n-1 .. 0, so a phase of n units loads n-1.
  function automatic logic [3:0] cnt_load(input int n);
    return 4'(n - 1);
  endfunction

endpackage

// File: rtl/qspi_xip_reader_if.sv
// Request/response and flash-side signals of the QSPI XIP read engine.
interface qspi_xip_reader_if #(
  parameter int LEN_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [23:0]      req_addr;
  logic [LEN_W-1:0] req_len;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             rd_last;
  logic             busy;
  logic             fr_sck;
  logic             fr_ce_n;
  logic [3:0]       fr_dout;
  logic             fr_douten;
  logic [3:0]       fr_din;

  modport slave (
    input  req_valid, req_addr, req_len, fr_din,
    output req_ready, rd_data, rd_valid, rd_last, busy,
           fr_sck, fr_ce_n, fr_dout, fr_douten
  );

  modport master (
    output req_valid, req_addr, req_len, fr_din,
    input  req_ready, rd_data, rd_valid, rd_last, busy,
           fr_sck, fr_ce_n, fr_dout, fr_douten
  );
endinterface

// File: rtl/qspi_xip_reader_sck_gen.sv
// HCLK/2 flash clock generator; parks SCK low whenever disabled.
module qspi_sck_gen (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic en,
  output logic sck,
  output logic drive,
  output logic sample
);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sck <= 1'b0;
    end else if (en) begin
      sck <= ~sck;
    end else begin
      sck <= 1'b0;
    end
  end

  // The edge ending a high phase both enters the next low phase and captures input.
  assign drive  = en & sck;
  assign sample = en & sck;

endmodule

// File: rtl/qspi_xip_reader.sv
// Quad I/O Fast Read (0xEB) engine serving byte-burst requests from the XIP side.
module qspi_xip_reader
  import qspi_flash_pkg::*;
#(
  parameter logic [7:0]  CMD          = DEFAULT_CMD,
  parameter logic [7:0]  MODE_BYTE    = 8'h00,
  parameter int unsigned DUMMY_CYCLES = 4,
  parameter int unsigned LEN_W        = 4,
  parameter int unsigned CSH_CYCLES   = 2
) (
  input logic               HCLK,
  input logic               HRESETn,
  qspi_xip_reader_if.slave  bus
);

  state_t           state;
  logic [3:0]       sck_cnt;
  logic [LEN_W-1:0] byte_cnt;
  logic [23:0]      shreg;
  logic             nib_lo;
  logic [3:0]       hi_nib;
  logic             ce_n;
  logic             douten;
  logic [3:0]       dout;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             rd_last;
  logic             req_ready;
  logic             sck_en;
  logic             sck;
  logic             drive;
  logic             sample;

  assign sck_en = (state != ST_IDLE) && (state != ST_CSH);

  qspi_sck_gen u_sck_gen (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .en      (sck_en),
    .sck     (sck),
    .drive   (drive),
    .sample  (sample)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      sck_cnt   <= '0;
      byte_cnt  <= '0;
      shreg     <= '0;
      nib_lo    <= 1'b0;
      hi_nib    <= '0;
      ce_n      <= 1'b1;
      douten    <= 1'b0;
      dout      <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            state     <= ST_CMD;
            req_ready <= 1'b0;
            ce_n      <= 1'b0;
            douten    <= 1'b1;
            dout      <= {3'b110, CMD[7]};
            sck_cnt   <= cnt_load(CMD_SCKS);
            shreg     <= bus.req_addr;
            byte_cnt  <= bus.req_len;
          end
        end
        ST_CMD: begin
          if (drive) begin
            if (sck_cnt != '0) begin
              sck_cnt <= sck_cnt - 4'd1;
              dout    <= {3'b110, CMD[sck_cnt[2:0] - 3'd1]};
            end else begin
              state   <= ST_ADDR;
              sck_cnt <= cnt_load(ADDR_SCKS);
              dout    <= shreg[23:20];
              shreg   <= {shreg[19:0], 4'h0};
            end
          end
        end
        ST_ADDR: begin
          if (drive) begin
            if (sck_cnt != '0) begin
              sck_cnt <= sck_cnt - 4'd1;
              dout    <= shreg[23:20];
              shreg   <= {shreg[19:0], 4'h0};
            end else begin
              state   <= ST_MODE;
              sck_cnt <= cnt_load(MODE_SCKS);
              dout    <= MODE_BYTE[7:4];
            end
          end
        end
        ST_MODE: begin
          if (drive) begin
            if (sck_cnt != '0) begin
              sck_cnt <= sck_cnt - 4'd1;
              dout    <= MODE_BYTE[3:0];
            end else begin
              state   <= ST_DUMMY;
              sck_cnt <= cnt_load(int'(DUMMY_CYCLES));
              douten  <= 1'b0;
              dout    <= '0;
            end
          end
        end
        ST_DUMMY: begin
          if (drive) begin
            if (sck_cnt != '0) begin
              sck_cnt <= sck_cnt - 4'd1;
            end else begin
              state  <= ST_DATA;
              nib_lo <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (sample) begin
            if (!nib_lo) begin
              hi_nib <= bus.fr_din;
              nib_lo <= 1'b1;
            end else begin
              nib_lo   <= 1'b0;
              rd_data  <= {hi_nib, bus.fr_din};
              rd_valid <= 1'b1;
              // Deselect on the final capture edge; SCK falls on this same edge and stays low.
              if (byte_cnt == '0) begin
                rd_last <= 1'b1;
                ce_n    <= 1'b1;
                state   <= ST_CSH;
                sck_cnt <= cnt_load(int'(CSH_CYCLES));
              end else begin
                byte_cnt <= byte_cnt - 1'b1;
              end
            end
          end
        end
        ST_CSH: begin
          if (sck_cnt != '0) begin
            sck_cnt <= sck_cnt - 4'd1;
          end else begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          ce_n      <= 1'b1;
          douten    <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.busy      = ~req_ready;
  assign bus.rd_data   = rd_data;
  assign bus.rd_valid  = rd_valid;
  assign bus.rd_last   = rd_last;
  assign bus.fr_sck    = sck;
  assign bus.fr_ce_n   = ce_n;
  assign bus.fr_dout   = dout;
  assign bus.fr_douten = douten;

endmodule

// File: tb/tb_qspi_xip_reader.sv
// Scoreboard bench for qspi_xip_reader with a reactive flash model (default and 8-dummy builds).
module tb_qspi_xip_reader;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  qspi_xip_reader_if #(.LEN_W(4)) ifa ();
  qspi_xip_reader_if #(.LEN_W(4)) ifb ();

  qspi_xip_reader #(.DUMMY_CYCLES(4)) dut_a (.HCLK(HCLK), .HRESETn(HRESETn), .bus(ifa));
  qspi_xip_reader #(.DUMMY_CYCLES(8)) dut_b (.HCLK(HCLK), .HRESETn(HRESETn), .bus(ifb));

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rx_rd = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  // Flash model: logs every rising SCK, serves mem[] nibbles during the data phase.
  logic [3:0] io_log[64];
  logic       oe_log[64];
  int         rcnt = 0;
  logic [7:0] mem[16];
  int         dj;
  logic [7:0] db;
  logic [3:0] din_a;

  always @(posedge ifa.fr_sck or negedge ifa.fr_ce_n) begin
    if (!ifa.fr_sck) begin
      rcnt <= 0;
    end else if (!ifa.fr_ce_n && rcnt < 64) begin
      io_log[rcnt] <= ifa.fr_dout;
      oe_log[rcnt] <= ifa.fr_douten;
      rcnt         <= rcnt + 1;
    end
  end

  always_comb begin
    dj    = rcnt - 21;
    db    = '0;
    din_a = '0;
    if (dj >= 0 && dj < 32) begin
      db    = mem[dj[4:1]];
      din_a = dj[0] ? db[3:0] : db[7:4];
    end
  end

  assign ifa.fr_din = din_a;
  assign ifb.fr_din = 4'h7;

  // Output monitors.
  logic [7:0] rx_d[64];
  logic       rx_l[64];
  logic       rx_c[64];
  int         rx_t[64];
  int         rx_wr = 0;
  int         rise_t[16];
  int         fall_t[16];
  int         rise_n = 0;
  int         fall_n = 0;
  logic       ce_prev = 1'b1;
  int         b_t = 0;
  int         b_n = 0;
  logic [7:0] b_d = '0;
  logic       b_l = 1'b0;

  always @(negedge HCLK) begin
    if (ifa.rd_valid && rx_wr < 64) begin
      rx_d[rx_wr] <= ifa.rd_data;
      rx_l[rx_wr] <= ifa.rd_last;
      rx_c[rx_wr] <= ifa.fr_ce_n;
      rx_t[rx_wr] <= cyc;
      rx_wr       <= rx_wr + 1;
    end
    if (ifa.fr_ce_n && !ce_prev && rise_n < 16) begin
      rise_t[rise_n] <= cyc;
      rise_n         <= rise_n + 1;
    end
    if (!ifa.fr_ce_n && ce_prev && fall_n < 16) begin
      fall_t[fall_n] <= cyc;
      fall_n         <= fall_n + 1;
    end
    ce_prev <= ifa.fr_ce_n;
    if (ifb.rd_valid) begin
      b_t <= cyc;
      b_d <= ifb.rd_data;
      b_l <= ifb.rd_last;
      b_n <= b_n + 1;
    end
  end

  task automatic send_a(input logic [23:0] addr, input logic [3:0] len, output int e0);
    @(negedge HCLK);
    ifa.req_addr  = addr;
    ifa.req_len   = len;
    ifa.req_valid = 1'b1;
    @(posedge HCLK);
    #1;
    e0 = cyc;
    ifa.req_valid = 1'b0;
  endtask

  task automatic get_rx(output bit ok, output int idx);
    int n = 0;
    while (rx_wr <= rx_rd && n < 200) begin
      @(negedge HCLK);
      #1;
      n++;
    end
    ok  = (rx_wr > rx_rd);
    idx = rx_rd;
    if (ok) rx_rd++;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (10) @(negedge HCLK);
    checks++; if (ifa.fr_ce_n !== 1'b1) begin failures++; $display("FAIL reset_ce_n got=%b want=1", ifa.fr_ce_n); end
    checks++; if (ifa.fr_sck !== 1'b0) begin failures++; $display("FAIL reset_sck got=%b want=0", ifa.fr_sck); end
    checks++; if (ifa.fr_douten !== 1'b0) begin failures++; $display("FAIL reset_douten got=%b want=0", ifa.fr_douten); end
    checks++; if (ifa.fr_dout !== 4'h0) begin failures++; $display("FAIL reset_dout got=%h want=0", ifa.fr_dout); end
    checks++; if (ifa.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", ifa.req_ready); end
    checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", ifa.busy); end
    checks++; if (ifa.rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h want=00", ifa.rd_data); end
    checks++; if (rx_wr !== 0) begin failures++; $display("FAIL reset_no_rd_valid got=%0d want=0", rx_wr); end
  endtask

  task automatic test_single();
    int         e0, idx;
    bit         ok, hold_ok, oe_ok, dum_ok, dat_ok;
    exp_t       e;
    logic [7:0] cmd_b;
    logic [23:0] a;
    logic [7:0] m;
    mem[0] = 8'hA5;
    e.d = 8'hA5; e.l = 1'b1;
    exp_q.push_back(e);
    send_a(24'h123456, 4'd0, e0);
    checks++; if (ifa.busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b want=1", ifa.busy); end
    get_rx(ok, idx);
    e = exp_q.pop_front();
    checks++;
    if (!ok) begin
      failures++; $display("FAIL single_timeout got=none want=rd_valid");
    end else begin
      if (rx_d[idx] !== e.d) begin failures++; $display("FAIL single_data got=%h want=%h", rx_d[idx], e.d); end
      checks++; if (rx_l[idx] !== e.l) begin failures++; $display("FAIL single_last got=%b want=%b", rx_l[idx], e.l); end
      checks++; if (rx_t[idx] !== e0 + 44) begin failures++; $display("FAIL single_latency got=%0d want=%0d", rx_t[idx] - e0, 44); end
      checks++; if (rx_c[idx] !== 1'b1) begin failures++; $display("FAIL single_ce_rise got=%b want=1", rx_c[idx]); end
    end
    cmd_b = '0; a = '0; m = '0;
    hold_ok = 1'b1; oe_ok = 1'b1; dum_ok = 1'b1; dat_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cmd_b = {cmd_b[6:0], io_log[k][0]};
      if (io_log[k][3:1] !== 3'b110) hold_ok = 1'b0;
    end
    for (int k = 8; k < 14; k++) a = {a[19:0], io_log[k]};
    m = {io_log[14], io_log[15]};
    for (int k = 0; k < 16; k++) if (oe_log[k] !== 1'b1) oe_ok = 1'b0;
    for (int k = 16; k < 20; k++) if (oe_log[k] !== 1'b0 || io_log[k] !== 4'h0) dum_ok = 1'b0;
    for (int k = 20; k < 22; k++) if (oe_log[k] !== 1'b0) dat_ok = 1'b0;
    checks++; if (cmd_b !== 8'hEB) begin failures++; $display("FAIL single_cmd got=%h want=eb", cmd_b); end
    checks++; if (!hold_ok) begin failures++; $display("FAIL single_hold_wp got=bad want=110"); end
    checks++; if (a !== 24'h123456) begin failures++; $display("FAIL single_addr got=%h want=123456", a); end
    checks++; if (m !== 8'h00) begin failures++; $display("FAIL single_mode got=%h want=00", m); end
    checks++; if (!oe_ok) begin failures++; $display("FAIL single_oe_hdr got=0 want=1"); end
    checks++; if (!dum_ok) begin failures++; $display("FAIL single_dummy got=driven want=released"); end
    checks++; if (!dat_ok) begin failures++; $display("FAIL single_data_oe got=1 want=0"); end
    checks++; if (rcnt !== 22) begin failures++; $display("FAIL single_sck_count got=%0d want=22", rcnt); end
    repeat (6) @(negedge HCLK);
  endtask

  task automatic test_burst();
    int         e0, idx, prev;
    bit         ok;
    exp_t       e;
    logic [23:0] a;
    for (int i = 0; i < 4; i++) begin
      mem[i] = 8'(i + 1);
      e.d = 8'(i + 1); e.l = (i == 3);
      exp_q.push_back(e);
    end
    send_a(24'h000100, 4'd3, e0);
    prev = e0 + 40;
    for (int i = 0; i < 4; i++) begin
      get_rx(ok, idx);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin
        failures++; $display("FAIL burst_timeout byte=%0d got=none want=rd_valid", i);
      end else begin
        if (rx_d[idx] !== e.d) begin failures++; $display("FAIL burst_data byte=%0d got=%h want=%h", i, rx_d[idx], e.d); end
        checks++; if (rx_l[idx] !== e.l) begin failures++; $display("FAIL burst_last byte=%0d got=%b want=%b", i, rx_l[idx], e.l); end
        checks++; if (rx_t[idx] - prev !== 4) begin failures++; $display("FAIL burst_spacing byte=%0d got=%0d want=4", i, rx_t[idx] - prev); end
        prev = rx_t[idx];
      end
    end
    a = '0;
    for (int k = 8; k < 14; k++) a = {a[19:0], io_log[k]};
    checks++; if (a !== 24'h000100) begin failures++; $display("FAIL burst_addr got=%h want=000100", a); end
    checks++; if (rcnt !== 28) begin failures++; $display("FAIL burst_sck_count got=%0d want=28", rcnt); end
    repeat (6) @(negedge HCLK);
  endtask

  task automatic test_back_to_back();
    int   r0, f0, idx, n;
    bit   ok;
    exp_t e;
    r0 = rise_n;
    f0 = fall_n;
    mem[0] = 8'h3C;
    e.d = 8'h3C; e.l = 1'b1;
    exp_q.push_back(e);
    exp_q.push_back(e);
    @(negedge HCLK);
    ifa.req_addr  = 24'hFFFFFF;
    ifa.req_len   = 4'd0;
    ifa.req_valid = 1'b1;
    get_rx(ok, idx);
    e = exp_q.pop_front();
    checks++;
    if (!ok) begin
      failures++; $display("FAIL b2b_first_timeout got=none want=rd_valid");
    end else begin
      if (rx_d[idx] !== e.d) begin failures++; $display("FAIL b2b_first_data got=%h want=%h", rx_d[idx], e.d); end
      checks++; if (ifa.req_ready !== 1'b0) begin failures++; $display("FAIL b2b_csh_ready got=%b want=0", ifa.req_ready); end
    end
    n = 0;
    while (fall_n < f0 + 2 && n < 100) begin @(negedge HCLK); #1; n++; end
    ifa.req_valid = 1'b0;
    checks++;
    if (fall_n < f0 + 2 || rise_n < r0 + 1) begin
      failures++; $display("FAIL b2b_second_accept got=none want=accept");
    end else begin
      if (fall_t[f0 + 1] - rise_t[r0] !== 3) begin
        failures++; $display("FAIL b2b_gap got=%0d want=3", fall_t[f0 + 1] - rise_t[r0]);
      end
      checks++; if (fall_t[f0 + 1] - rise_t[r0] < 2) begin failures++; $display("FAIL b2b_ce_high got=%0d want>=2", fall_t[f0 + 1] - rise_t[r0]); end
    end
    get_rx(ok, idx);
    e = exp_q.pop_front();
    checks++;
    if (!ok) begin
      failures++; $display("FAIL b2b_second_timeout got=none want=rd_valid");
    end else if (rx_d[idx] !== e.d || rx_l[idx] !== e.l) begin
      failures++; $display("FAIL b2b_second_data got=%h/%b want=%h/%b", rx_d[idx], rx_l[idx], e.d, e.l);
    end
    repeat (8) @(negedge HCLK);
    checks++; if (fall_n !== f0 + 2) begin failures++; $display("FAIL b2b_no_third got=%0d want=%0d", fall_n - f0, 2); end
  endtask

  task automatic test_dummy8();
    int e0, b0, n;
    b0 = b_n;
    @(negedge HCLK);
    ifb.req_addr  = 24'h00ABCD;
    ifb.req_len   = 4'd0;
    ifb.req_valid = 1'b1;
    @(posedge HCLK);
    #1;
    e0 = cyc;
    ifb.req_valid = 1'b0;
    n = 0;
    while (b_n == b0 && n < 200) begin @(negedge HCLK); #1; n++; end
    checks++;
    if (b_n == b0) begin
      failures++; $display("FAIL dummy8_timeout got=none want=rd_valid");
    end else begin
      if (b_t !== e0 + 52) begin failures++; $display("FAIL dummy8_latency got=%0d want=52", b_t - e0); end
      checks++; if (b_d !== 8'h77) begin failures++; $display("FAIL dummy8_data got=%h want=77", b_d); end
      checks++; if (b_l !== 1'b1) begin failures++; $display("FAIL dummy8_last got=%b want=1", b_l); end
    end
    repeat (6) @(negedge HCLK);
  endtask

  task automatic test_reset_mid();
    int e0, w0;
    w0 = rx_wr;
    send_a(24'hABCDEF, 4'd5, e0);
    repeat (18) @(posedge HCLK);
    #1;
    checks++; if (ifa.fr_ce_n !== 1'b0) begin failures++; $display("FAIL mid_pre_ce_n got=%b want=0", ifa.fr_ce_n); end
    checks++; if (ifa.fr_douten !== 1'b1) begin failures++; $display("FAIL mid_pre_douten got=%b want=1", ifa.fr_douten); end
    HRESETn = 1'b0;
    #1;
    checks++; if (ifa.fr_ce_n !== 1'b1) begin failures++; $display("FAIL mid_ce_n got=%b want=1", ifa.fr_ce_n); end
    checks++; if (ifa.fr_sck !== 1'b0) begin failures++; $display("FAIL mid_sck got=%b want=0", ifa.fr_sck); end
    checks++; if (ifa.fr_douten !== 1'b0) begin failures++; $display("FAIL mid_douten got=%b want=0", ifa.fr_douten); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (60) @(negedge HCLK);
    checks++; if (rx_wr !== w0) begin failures++; $display("FAIL mid_no_rd_valid got=%0d want=%0d", rx_wr, w0); end
    checks++; if (ifa.req_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b want=1", ifa.req_ready); end
  endtask

  initial begin
    ifa.req_valid = 1'b0;
    ifa.req_addr  = '0;
    ifa.req_len   = '0;
    ifb.req_valid = 1'b0;
    ifb.req_addr  = '0;
    ifb.req_len   = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_single();
    test_burst();
    test_back_to_back();
    test_dummy8();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
